// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync FIFO write port among NREQ valid/ready producers.
// Define SYNC_FIFO_ARB_TAG_EN to prepend the granted requester index to every FIFO word.
module sync_fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int IDW       = $clog2(NREQ),
`ifdef SYNC_FIFO_ARB_TAG_EN
    localparam int FDW      = IDW + WIDTH
`else
    localparam int FDW      = WIDTH
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_req_data,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic                  i_fifo_ready,
    output logic                  o_fifo_wr_en,
    output logic [FDW-1:0]        o_fifo_data,
    output logic [IDW-1:0]        o_grant_id,
    output logic                  o_busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [IDW-1:0]   r_grantId;
    logic [IDW-1:0]   r_rrPtr;
    logic [CW-1:0]    r_burstCnt;
    logic [IDW-1:0]   w_grantNext;
    logic [IDW-1:0]   w_rrNext;
    logic [CW-1:0]    w_burstNext;
    logic [IDW-1:0]   w_sel;
    logic [IDW-1:0]   w_wrapPtr;
    logic             w_anyValid;
    logic             w_grantValid;
    logic             w_xfer;
    logic [WIDTH-1:0] w_payload;

    // First valid requester at or after r_rrPtr; the wrap is explicit so odd NREQ works.
    always_comb begin
        int idx;
        idx        = 0;
        w_sel      = '0;
        w_anyValid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(r_rrPtr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_anyValid && i_req_valid[idx]) begin
                w_anyValid = 1'b1;
                w_sel      = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_grantValid = 1'b0;
        w_payload    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grantId == IDW'(i)) begin
                w_grantValid = i_req_valid[i];
                w_payload    = i_req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_wrapPtr = (r_grantId == IDW'(NREQ - 1)) ? '0 : r_grantId + 1'b1;
    assign o_busy    = (r_state == BURST);
    assign w_xfer    = o_busy & w_grantValid & i_fifo_ready;

    always_comb begin
        w_stateNext = r_state;
        w_grantNext = r_grantId;
        w_burstNext = r_burstCnt;
        w_rrNext    = r_rrPtr;
        case (r_state)
            IDLE: begin
                if (w_anyValid) begin
                    w_grantNext = w_sel;
                    w_burstNext = '0;
                    w_stateNext = BURST;
                end
            end
            BURST: begin
                if (w_xfer) begin
                    if (r_burstCnt == CW'(MAX_BURST - 1)) begin
                        w_stateNext = IDLE;
                        w_rrNext    = w_wrapPtr;
                    end else begin
                        w_burstNext = r_burstCnt + 1'b1;
                    end
                end else if (!w_grantValid) begin
                    w_stateNext = IDLE;
                    w_rrNext    = w_wrapPtr;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_grantId  <= '0;
            r_rrPtr    <= '0;
            r_burstCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_grantId  <= w_grantNext;
            r_rrPtr    <= w_rrNext;
            r_burstCnt <= w_burstNext;
        end
    end

    // Outputs are gated by state so a reset mid-burst drops the in-flight word.
    always_comb begin
        o_req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (o_busy && r_grantId == IDW'(i)) o_req_ready[i] = i_fifo_ready;
        end
    end

    assign o_fifo_wr_en = w_xfer;
    assign o_grant_id   = r_grantId;

`ifdef SYNC_FIFO_ARB_TAG_EN
    assign o_fifo_data = o_busy ? {r_grantId, w_payload} : '0;
`else
    assign o_fifo_data = o_busy ? w_payload : '0;
`endif

endmodule
